// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data memory model and responder on the memory side of the load/store unit's
// read/write bus. Read and write requests are accepted every cycle (there is no
// ready). Read data comes back after a fixed RD_LATENCY with in-order,
// one-cycle response pulses. A write and a read to the same word on the same
// edge forward the new write data to the read (write-first). Reads and writes
// that are out of range or misaligned are flagged per response and stickily.
//
// Ports:
//   clk           single clock, rising-edge
//   rst           asynchronous, active-low reset
//   mem_rd_valid  read request (always accepted)
//   mem_rd_addr   read byte address
//   mem_rd_resp   one-cycle read response pulse
//   mem_rd_data   read data, zero when mem_rd_resp=0
//   mem_rd_err    read error, zero when mem_rd_resp=0
//   mem_wr_valid  write request (always accepted)
//   mem_wr_addr   write byte address
//   mem_wr_data   write data
//   err_sticky    set by any read or write error, cleared only by reset
//   rd_cnt        accepted reads (wraps)
//   wr_cnt        committed, non-dropped writes (wraps)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_valid,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_resp,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_err,
    input  logic              mem_wr_valid,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              err_sticky,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Byte-address limit, one bit wider than the address so the compare
    // cannot overflow even when DEPTH_WORDS*4 equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;

    // ------------------------------------------------------------------
    // Address decode and checks
    // ------------------------------------------------------------------
    logic             rd_oor;
    logic             rd_mis;
    logic             rd_err;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_oor;
    logic             wr_mis;
    logic             wr_err;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_commit;
    logic             rd_fwd;

    assign rd_oor = ({1'b0, mem_rd_addr} >= ADDR_LIMIT);
    assign rd_mis = |mem_rd_addr[1:0];
    assign rd_err = rd_oor | rd_mis;
    assign rd_idx = mem_rd_addr[IDX_W+1:2];

    assign wr_oor = ({1'b0, mem_wr_addr} >= ADDR_LIMIT);
    assign wr_mis = |mem_wr_addr[1:0];
    assign wr_err = wr_oor | wr_mis;
    assign wr_idx = mem_wr_addr[IDX_W+1:2];

    // Misaligned writes still commit to their word index; only out-of-range
    // writes are dropped.
    assign wr_commit = mem_wr_valid & ~wr_oor;

    // Same-edge write to the same word wins over the stored contents.
    assign rd_fwd = wr_commit & (wr_idx == rd_idx);

    // ------------------------------------------------------------------
    // Storage and read pipeline
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              valid_reg [RD_LATENCY];
    logic [DATA_W-1:0] data_reg  [RD_LATENCY];
    logic              err_reg   [RD_LATENCY];

    logic              err_sticky_reg;
    logic [31:0]       rd_cnt_reg;
    logic [31:0]       wr_cnt_reg;

    // Stage 0 is the registered memory read. Storage itself is never reset;
    // the reset branch only clears control state, and writes are ignored
    // while reset is held because the write sits in the non-reset branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg[0]   <= 1'b0;
            data_reg[0]    <= '0;
            err_reg[0]     <= 1'b0;
            err_sticky_reg <= 1'b0;
            rd_cnt_reg     <= '0;
            wr_cnt_reg     <= '0;
        end else begin
            if (wr_commit) begin
                mem[wr_idx] <= mem_wr_data;
            end

            valid_reg[0] <= mem_rd_valid;
            err_reg[0]   <= mem_rd_valid & rd_err;
            if (mem_rd_valid && !rd_oor) begin
                data_reg[0] <= rd_fwd ? mem_wr_data : mem[rd_idx];
            end else begin
                data_reg[0] <= '0;
            end

            if (mem_rd_valid) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
            if (wr_commit) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
            if ((mem_rd_valid && rd_err) || (mem_wr_valid && wr_err)) begin
                err_sticky_reg <= 1'b1;
            end
        end
    end

    // Remaining stages simply shift; there is no stall, so every capture
    // emerges exactly RD_LATENCY-1 edges later.
    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    err_reg[gi]   <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    data_reg[gi]  <= data_reg[gi-1];
                    err_reg[gi]   <= err_reg[gi-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs (data and err masked outside the response pulse)
    // ------------------------------------------------------------------
    assign mem_rd_resp = valid_reg[RD_LATENCY-1];
    assign mem_rd_data = valid_reg[RD_LATENCY-1] ? data_reg[RD_LATENCY-1] : '0;
    assign mem_rd_err  = valid_reg[RD_LATENCY-1] & err_reg[RD_LATENCY-1];

    assign err_sticky = err_sticky_reg;
    assign rd_cnt     = rd_cnt_reg;
    assign wr_cnt     = wr_cnt_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives three instances (RD_LATENCY = 2, 1, 4) with the same request stream.
// A reference model records, for every clock edge, what read request was
// sampled and what it should return; a response is expected RD_LATENCY-1
// edges after capture. Storage is modelled as a sparse word array and the
// counters/sticky flag as plain variables.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_addr;
    logic        mem_wr_valid;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    logic        resp2, err2, sticky2;
    logic [31:0] data2, rdc2, wrc2;
    logic        resp1, err1, sticky1;
    logic [31:0] data1, rdc1, wrc1;
    logic        resp4, err4, sticky4;
    logic [31:0] data4, rdc4, wrc4;

    dmem_responder #(.RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_resp(resp2), .mem_rd_data(data2), .mem_rd_err(err2),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .err_sticky(sticky2), .rd_cnt(rdc2), .wr_cnt(wrc2)
    );

    dmem_responder #(.RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_resp(resp1), .mem_rd_data(data1), .mem_rd_err(err1),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .err_sticky(sticky1), .rd_cnt(rdc1), .wr_cnt(wrc1)
    );

    dmem_responder #(.RD_LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_resp(resp4), .mem_rd_data(data4), .mem_rd_err(err4),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .err_sticky(sticky4), .rd_cnt(rdc4), .wr_cnt(wrc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          checks   = 0;
    int          failures = 0;
    int          n        = 0;          // clock edges so far
    bit          hv [8192];             // read sampled at edge k
    bit          he [8192];             // expected err
    bit          hk [8192];             // expected data is known
    logic [31:0] hd [8192];             // expected data
    logic [31:0] mmem [int];            // written words, keyed by word index
    logic [31:0] m_rd_cnt = 0;
    logic [31:0] m_wr_cnt = 0;
    bit          m_sticky = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat, input logic resp,
                             input logic [31:0] data, input logic err);
        int k;
        bit ev, ee, ek;
        logic [31:0] ed;
        k  = n - lat + 1;
        ev = 1'b0; ee = 1'b0; ek = 1'b1; ed = 32'h0;
        if (k >= 1) begin
            ev = hv[k];
            if (ev) begin
                ee = he[k];
                ek = hk[k];
                ed = hd[k];
            end
        end
        chk({tag, "_resp"}, {31'b0, resp}, {31'b0, ev});
        chk({tag, "_err"}, {31'b0, err}, {31'b0, ee});
        if (ek) chk({tag, "_data"}, data, ed);
    endtask

    task automatic check_outputs();
        check_lat("lat2", 2, resp2, data2, err2);
        check_lat("lat1", 1, resp1, data1, err1);
        check_lat("lat4", 4, resp4, data4, err4);
        chk("rd_cnt", rdc2, m_rd_cnt);
        chk("wr_cnt", wrc2, m_wr_cnt);
        chk("err_sticky", {31'b0, sticky2}, {31'b0, m_sticky});
    endtask

    // One clock cycle: drive request, apply model at the edge, check at negedge.
    task automatic cycle(input bit rv, input logic [31:0] ra,
                         input bit wv, input logic [31:0] wa, input logic [31:0] wd);
        bit r_oor, w_ok;
        int ridx, widx;
        mem_rd_valid = rv; mem_rd_addr = ra;
        mem_wr_valid = wv; mem_wr_addr = wa; mem_wr_data = wd;
        @(posedge clk);
        n++;
        hv[n] = 1'b0;
        if (rst) begin
            r_oor = (ra >= 32'h1000);
            ridx  = int'(ra >> 2);
            w_ok  = wv && (wa < 32'h1000);
            widx  = int'(wa >> 2);
            if (rv) begin
                hv[n] = 1'b1;
                he[n] = r_oor || (ra[1:0] != 2'b00);
                hk[n] = 1'b1;
                if (r_oor)                  hd[n] = 32'h0;
                else if (w_ok && widx == ridx) hd[n] = wd;
                else if (mmem.exists(ridx)) hd[n] = mmem[ridx];
                else                         hk[n] = 1'b0;
                m_rd_cnt++;
                if (he[n]) m_sticky = 1'b1;
            end
            if (wv) begin
                if (w_ok) begin
                    mmem[widx] = wd;
                    m_wr_cnt++;
                end
                if (!w_ok || wa[1:0] != 2'b00) m_sticky = 1'b1;
            end
        end
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_wr_valid = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // Assert reset between edges; everything in flight is discarded.
    task automatic assert_reset();
        rst = 1'b0;
        #1;
        for (int k = 1; k <= n; k++) hv[k] = 1'b0;
        m_rd_cnt = 0;
        m_wr_cnt = 0;
        m_sticky = 1'b0;
        mmem.delete();
        check_outputs();
    endtask

    logic [31:0] r, ra, wa;

    initial begin
        rst = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_addr = '0;
        mem_wr_valid = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        #1;
        check_outputs();                                    // reset state
        // Requests under reset are ignored.
        cycle(1'b1, 32'h10, 1'b1, 32'h10, 32'h0BAD0BAD);
        cycle(1'b1, 32'h1000, 1'b1, 32'h2000, 32'h1);
        rst = 1'b1;
        #1;
        check_outputs();

        // Write then read.
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF);
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("wr_rd_resp", {31'b0, resp2}, 32'h1);
        chk("wr_rd_data", data2, 32'hDEADBEEF);
        chk("wr_rd_cnts", {rdc2[15:0], wrc2[15:0]}, 32'h0001_0001);
        idle(3);

        // Same-edge forwarding; a later write must not alter the in-flight read.
        cycle(1'b1, 32'h20, 1'b1, 32'h20, 32'h12345678);
        cycle(1'b0, 32'h0, 1'b1, 32'h20, 32'hAAAA5555);
        chk("fwd_data", data2, 32'h12345678);
        idle(3);

        // Streaming.
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 32'(4*i), 32'(i));
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(4*i), 1'b0, 32'h0, 32'h0);
        idle(4);

        // Errors.
        cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
        chk("oor_sticky", {31'b0, sticky2}, 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 32'h1000, 32'h77);
        chk("oor_rd_err", {31'b0, err2}, 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 32'h0C, 32'h55);
        cycle(1'b1, 32'h0D, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("mis_rd_data", data2, 32'h55);
        idle(4);

        // Fill a small region, then random mixed traffic.
        for (int i = 0; i < 64; i++) cycle(1'b0, 32'h0, 1'b1, 32'(4*i), $urandom);
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            case (r[2:0])
                3'd0:    ra = 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
                3'd1:    ra = {24'h0, r[15:10], 2'b01} | {30'h0, r[9:8]};
                default: ra = {22'h0, r[15:10], 2'b00};
            endcase
            case (r[18:16])
                3'd0:    wa = 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
                3'd1:    wa = {24'h0, r[27:22], 2'b10};
                3'd2,
                3'd3:    wa = ra;
                default: wa = {22'h0, r[27:22], 2'b00};
            endcase
            cycle(r[3], ra, r[4], wa, $urandom);
        end
        idle(4);

        // Reset mid-flight: read, then reset one cycle later.
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        assert_reset();
        cycle(1'b1, 32'h10, 1'b1, 32'h14, 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_outputs();
        idle(4);

        // Traffic after reset.
        cycle(1'b0, 32'h0, 1'b1, 32'h40, 32'hCAFEF00D);
        cycle(1'b1, 32'h40, 1'b1, 32'h44, 32'h0F0F0F0F);
        cycle(1'b1, 32'h44, 1'b0, 32'h0, 32'h0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
